// File: rtl/instr_encoder_loader.sv
// Re-encodes decoded control bundles into 16-bit instruction words and streams
// them into instruction memory through a small skid FIFO and a registered write port.
module instr_encoder_loader #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [1:0]    reg_dst,
  input  logic [1:0]    mem_to_reg,
  input  logic [1:0]    alu_op,
  input  logic          jump,
  input  logic          branch,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic          alu_src,
  input  logic          reg_write,
  input  logic          sign_or_zero,
  input  logic [2:0]    rs,
  input  logic [2:0]    rt,
  input  logic [2:0]    rd,
  input  logic [3:0]    funct,
  input  logic [12:0]   imm,
  input  logic          imem_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [15:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] err_index,
  output logic [AW:0]   count
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_e;
  typedef struct packed {
    logic [15:0] word;
    logic        last;
    logic        illegal;
  } entry_t;

  state_e        state_q;
  entry_t        mem_q [DEPTH];
  logic [PW:0]   wp_q, rp_q;
  logic          last_acc_q, we_q, out_last_q, done_q, err_q;
  logic [AW-1:0] addr_q, err_idx_q;
  logic [15:0]   wdata_q;
  logic [AW:0]   cnt_q;

  logic [12:0]   ctrl;
  logic [2:0]    op;
  logic          illegal;
  logic [15:0]   word;

  // Only exact matches of a decoder row recover an opcode.
  always_comb begin
    ctrl    = {reg_dst, mem_to_reg, alu_op, jump, branch, mem_read, mem_write,
               alu_src, reg_write, sign_or_zero};
    op      = 3'd0;
    illegal = 1'b0;
    case (ctrl)
      13'b01_00_00_0000011: op = 3'd0;
      13'b00_00_10_0000110: op = 3'd1;
      13'b00_00_00_1000001: op = 3'd2;
      13'b10_10_00_1000011: op = 3'd3;
      13'b00_01_11_0010111: op = 3'd4;
      13'b00_00_11_0001101: op = 3'd5;
      13'b00_00_01_0100001: op = 3'd6;
      default:              illegal = 1'b1;
    endcase
    word = {op, rs, rt, imm[6:0]};
    case (op)
      3'd0:       word = {op, rs, rt, rd, funct};
      3'd2, 3'd3: word = {op, imm};
      default:    ;
    endcase
  end

  logic   empty, full, push, pop, wr_done, addr_max;
  entry_t head;
  logic [AW-1:0] next_addr;

  assign empty     = (wp_q == rp_q);
  assign full      = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign head      = mem_q[rp_q[PW-1:0]];
  assign in_ready  = (state_q == LOAD) && !full && !last_acc_q;
  assign push      = in_valid && in_ready;
  assign wr_done   = we_q && imem_ready;
  assign addr_max  = (addr_q == {AW{1'b1}});
  assign next_addr = wr_done ? addr_q + AW'(1) : addr_q;
  // Never pop into a write that ends the load (last word or top address).
  assign pop = (state_q == LOAD) && !empty && (!we_q || imem_ready) &&
               !(wr_done && (out_last_q || addr_max));

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[PW-1:0]] <= '{word: word, last: in_last, illegal: illegal};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wp_q       <= '0;
      rp_q       <= '0;
      last_acc_q <= 1'b0;
      we_q       <= 1'b0;
      out_last_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (push) begin
            wp_q <= wp_q + (PW+1)'(1);
            if (in_last) last_acc_q <= 1'b1;
          end
          if (wr_done) begin
            we_q  <= 1'b0;
            cnt_q <= cnt_q + (AW+1)'(1);
            if (!addr_max) addr_q <= addr_q + AW'(1);
            if (out_last_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (addr_max) begin
              state_q   <= ERROR;
              err_q     <= 1'b1;
              err_idx_q <= addr_q;
            end
          end
          if (pop) begin
            rp_q <= rp_q + (PW+1)'(1);
            if (head.illegal) begin
              state_q   <= ERROR;
              err_q     <= 1'b1;
              err_idx_q <= next_addr;
            end else begin
              we_q       <= 1'b1;
              wdata_q    <= head.word;
              out_last_q <= head.last;
            end
          end
        end
        default: if (start) begin
          state_q    <= LOAD;
          wp_q       <= '0;
          rp_q       <= '0;
          last_acc_q <= 1'b0;
          addr_q     <= '0;
          cnt_q      <= '0;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
          err_idx_q  <= '0;
        end
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == LOAD);
  assign done       = done_q;
  assign err        = err_q;
  assign err_index  = err_idx_q;
  assign count      = cnt_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: per-opcode vector table plus hand sequences for streaming,
// backpressure, illegal bundles, address overflow and mid-load reset.
module tb_instr_encoder_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_a, start_b, in_valid, in_last, imem_ready;
  logic [1:0] reg_dst, mem_to_reg, alu_op;
  logic jump, branch, mem_read, mem_write, alu_src, reg_write, sign_or_zero;
  logic [2:0] rs, rt, rd;
  logic [3:0] funct;
  logic [12:0] imm;

  logic a_rdy, a_we, a_busy, a_done, a_err;
  logic [7:0] a_addr, a_eidx;
  logic [15:0] a_wdata;
  logic [8:0] a_cnt;
  logic b_rdy, b_we, b_busy, b_done, b_err;
  logic [1:0] b_addr, b_eidx;
  logic [15:0] b_wdata;
  logic [2:0] b_cnt;

  instr_encoder_loader #(.AW(8), .DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid), .in_ready(a_rdy),
    .in_last(in_last), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
    .jump(jump), .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .sign_or_zero(sign_or_zero),
    .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .imem_ready(imem_ready),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata), .busy(a_busy),
    .done(a_done), .err(a_err), .err_index(a_eidx), .count(a_cnt));

  instr_encoder_loader #(.AW(2), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid), .in_ready(b_rdy),
    .in_last(in_last), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
    .jump(jump), .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .sign_or_zero(sign_or_zero),
    .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .imem_ready(imem_ready),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata), .busy(b_busy),
    .done(b_done), .err(b_err), .err_index(b_eidx), .count(b_cnt));

  logic sel;
  logic cur_rdy, cur_we, cur_busy, cur_done, cur_err;
  logic [7:0] cur_addr, cur_eidx;
  logic [15:0] cur_wdata;
  logic [8:0] cur_cnt;
  assign cur_rdy   = sel ? b_rdy : a_rdy;
  assign cur_we    = sel ? b_we : a_we;
  assign cur_busy  = sel ? b_busy : a_busy;
  assign cur_done  = sel ? b_done : a_done;
  assign cur_err   = sel ? b_err : a_err;
  assign cur_addr  = sel ? {6'd0, b_addr} : a_addr;
  assign cur_eidx  = sel ? {6'd0, b_eidx} : a_eidx;
  assign cur_wdata = sel ? b_wdata : a_wdata;
  assign cur_cnt   = sel ? {6'd0, b_cnt} : a_cnt;

  localparam logic [12:0] C_ADD = 13'b01_00_00_0000011, C_SLI = 13'b00_00_10_0000110,
                          C_J   = 13'b00_00_00_1000001, C_JAL = 13'b10_10_00_1000011,
                          C_LW  = 13'b00_01_11_0010111, C_SW  = 13'b00_00_11_0001101,
                          C_BEQ = 13'b00_00_01_0100001;

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [7:0]  wa[$];
  logic [15:0] wd[$];
  int          wc[$];

  always @(posedge clk) cyc <= cyc + 1;
  // A write observed here completes on the next rising edge (imem_ready only changes after edges).
  always @(negedge clk) if (cur_we && imem_ready) begin
    wa.push_back(cur_addr); wd.push_back(cur_wdata); wc.push_back(cyc);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete();
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic set_beat(input logic [12:0] c, input logic [2:0] s, input logic [2:0] t,
                          input logic [2:0] d, input logic [3:0] f, input logic [12:0] im,
                          input logic lst);
    {reg_dst, mem_to_reg, alu_op, jump, branch, mem_read, mem_write, alu_src,
     reg_write, sign_or_zero} = c;
    rs = s; rt = t; rd = d; funct = f; imm = im; in_last = lst;
  endtask

  task automatic send(input logic [12:0] c, input logic [2:0] s, input logic [2:0] t,
                      input logic [2:0] d, input logic [3:0] f, input logic [12:0] im,
                      input logic lst);
    bit ok = 0;
    set_beat(c, s, t, d, f, im, lst);
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cur_rdy) begin ok = 1; @(posedge clk); #1; break; end
    end
    in_valid = 1'b0;
    chk("beat_accepted", 32'(ok), 1);
  endtask

  task automatic wait_status();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cur_done || cur_err) begin ok = 1; break; end
    end
    chk("status_reached", 32'(ok), 1);
  endtask

  typedef struct {
    logic [12:0] c;
    logic [2:0]  s, t, d;
    logic [3:0]  f;
    logic [12:0] im;
    logic [15:0] exp_word;
    bit          exp_ill;
  } vec_t;
  vec_t vt[11];

  initial begin
    int acc;
    bit took;
    vt[0]  = '{C_ADD, 3'd1, 3'd2, 3'd3, 4'h0, 13'h0000, 16'h0530, 1'b0};
    vt[1]  = '{C_SLI, 3'd3, 3'd4, 3'd7, 4'hF, 13'h1FFF, 16'h2E7F, 1'b0};
    vt[2]  = '{C_J,   3'd7, 3'd7, 3'd7, 4'hF, 13'h1ABC, 16'h5ABC, 1'b0};
    vt[3]  = '{C_JAL, 3'd0, 3'd0, 3'd0, 4'h0, 13'h0001, 16'h6001, 1'b0};
    vt[4]  = '{C_LW,  3'd2, 3'd5, 3'd0, 4'h0, 13'h0007, 16'h8A87, 1'b0};
    vt[5]  = '{C_SW,  3'd7, 3'd0, 3'd1, 4'h3, 13'h0055, 16'hBC55, 1'b0};
    vt[6]  = '{C_BEQ, 3'd1, 3'd1, 3'd0, 4'h0, 13'h0F80, 16'hC480, 1'b0};
    vt[7]  = '{13'b01_00_00_0000010, 3'd1, 3'd2, 3'd3, 4'h0, 13'h0, 16'h0, 1'b1};
    vt[8]  = '{13'b00_00_00_0000000, 3'd0, 3'd0, 3'd0, 4'h0, 13'h0, 16'h0, 1'b1};
    vt[9]  = '{13'b00_00_00_1100001, 3'd0, 3'd0, 3'd0, 4'h0, 13'h0, 16'h0, 1'b1};
    vt[10] = '{13'b00_01_10_0010111, 3'd0, 3'd0, 3'd0, 4'h0, 13'h0, 16'h0, 1'b1};

    sel = 0; reset = 1; start_a = 0; start_b = 0; in_valid = 0; imem_ready = 1;
    set_beat(13'd0, 3'd0, 3'd0, 3'd0, 4'd0, 13'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_we", a_we, 0);       chk("rst_addr", a_addr, 0);  chk("rst_wdata", a_wdata, 0);
    chk("rst_rdy", a_rdy, 0);     chk("rst_busy", a_busy, 0);  chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);     chk("rst_eidx", a_eidx, 0);  chk("rst_cnt", a_cnt, 0);

    // One single-beat load per vector.
    foreach (vt[k]) begin
      clear_log();
      do_start();
      chk("vec_busy", cur_busy, 1);
      send(vt[k].c, vt[k].s, vt[k].t, vt[k].d, vt[k].f, vt[k].im, 1'b1);
      wait_status();
      if (!vt[k].exp_ill) begin
        chk("vec_nwr", wa.size(), 1);
        if (wa.size() > 0) begin chk("vec_word", wd[0], vt[k].exp_word); chk("vec_addr", wa[0], 0); end
        chk("vec_done", cur_done, 1); chk("vec_err", cur_err, 0); chk("vec_cnt", cur_cnt, 1);
      end else begin
        chk("ill_nwr", wa.size(), 0);
        chk("ill_err", cur_err, 1); chk("ill_done", cur_done, 0);
        chk("ill_eidx", cur_eidx, 0); chk("ill_cnt", cur_cnt, 0);
      end
      chk("vec_idle_busy", cur_busy, 0);
    end

    // LW then J back to back: latency and consecutive writes.
    clear_log();
    do_start();
    set_beat(C_LW, 3'd2, 3'd5, 3'd0, 4'd0, 13'h0007, 1'b0);
    in_valid = 1;
    @(negedge clk); chk("s2_rdy0", a_rdy, 1);
    @(posedge clk); #1;
    set_beat(C_J, 3'd0, 3'd0, 3'd0, 4'd0, 13'h0040, 1'b1);
    @(negedge clk); chk("s2_lat_we0", a_we, 0); chk("s2_rdy1", a_rdy, 1);
    @(posedge clk); #1; in_valid = 0;
    @(negedge clk); chk("s2_we1", a_we, 1); chk("s2_w1", a_wdata, 16'h8A87); chk("s2_a1", a_addr, 0);
    @(negedge clk); chk("s2_we2", a_we, 1); chk("s2_w2", a_wdata, 16'h4040); chk("s2_a2", a_addr, 1);
    wait_status();
    chk("s2_done", a_done, 1); chk("s2_cnt", a_cnt, 2); chk("s2_nwr", wa.size(), 2);
    if (wc.size() == 2) chk("s2_consec", wc[1] - wc[0], 1);

    // Backpressure: imem stalled for 10 cycles while 6 beats are offered.
    clear_log();
    imem_ready = 0;
    do_start();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      set_beat(C_ADD, 3'd1, 3'd2, 3'd3, 4'(acc), 13'd0, acc == 5);
      in_valid = (acc < 6);
      @(negedge clk);
      took = in_valid && a_rdy;
      @(posedge clk); #1;
      if (took) acc++;
    end
    @(negedge clk);
    chk("bp_accepted", acc, 5); chk("bp_rdy", a_rdy, 0);
    chk("bp_we", a_we, 1); chk("bp_addr", a_addr, 0); chk("bp_wdata", a_wdata, 16'h0530);
    @(posedge clk); #1;
    imem_ready = 1;
    for (int i = 0; i < 20 && acc < 6; i++) begin
      @(negedge clk);
      took = in_valid && a_rdy;
      @(posedge clk); #1;
      if (took) acc++;
    end
    in_valid = 0;
    chk("bp_all_accepted", acc, 6);
    wait_status();
    chk("bp_nwr", wa.size(), 6); chk("bp_done", a_done, 1); chk("bp_cnt", a_cnt, 6);
    for (int i = 0; i < 6 && i < wa.size(); i++) begin
      chk("bp_word", wd[i], 16'h0530 | 16'(i));
      chk("bp_waddr", wa[i], 8'(i));
    end

    // Illegal third beat.
    clear_log();
    do_start();
    send(C_ADD, 3'd1, 3'd2, 3'd3, 4'd1, 13'd0, 1'b0);
    send(C_ADD, 3'd1, 3'd2, 3'd3, 4'd2, 13'd0, 1'b0);
    send(13'b00_00_00_1100001, 3'd0, 3'd0, 3'd0, 4'd0, 13'd0, 1'b0);
    wait_status();
    repeat (5) @(negedge clk);
    chk("il_err", a_err, 1); chk("il_done", a_done, 0); chk("il_eidx", a_eidx, 2);
    chk("il_cnt", a_cnt, 2); chk("il_nwr", wa.size(), 2); chk("il_busy", a_busy, 0);
    chk("il_rdy", a_rdy, 0);
    if (wd.size() == 2) begin chk("il_w0", wd[0], 16'h0531); chk("il_w1", wd[1], 16'h0532); end

    // Address overflow on the AW=2 instance.
    clear_log();
    sel = 1;
    do_start();
    for (int i = 0; i < 5; i++) send(C_SW, 3'(i), 3'd0, 3'd0, 4'd0, 13'd0, i == 4);
    wait_status();
    repeat (3) @(negedge clk);
    chk("ov_err", b_err, 1); chk("ov_done", b_done, 0); chk("ov_eidx", b_eidx, 3);
    chk("ov_nwr", wa.size(), 4); chk("ov_cnt", b_cnt, 4);
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      chk("ov_waddr", wa[i], 8'(i));
      chk("ov_word", wd[i], 16'hA000 | 16'(i << 10));
    end
    @(posedge clk); #1;
    sel = 0;

    // Reset mid-load with words pending, then a fresh load.
    imem_ready = 0;
    do_start();
    for (int i = 0; i < 4; i++) send(C_ADD, 3'd1, 3'd2, 3'd3, 4'(i), 13'd0, 1'b0);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("mr_we", a_we, 0); chk("mr_addr", a_addr, 0); chk("mr_wdata", a_wdata, 0);
    chk("mr_rdy", a_rdy, 0); chk("mr_busy", a_busy, 0); chk("mr_cnt", a_cnt, 0);
    chk("mr_err", a_err, 0); chk("mr_done", a_done, 0);
    clear_log();
    imem_ready = 1;
    do_start();
    send(C_JAL, 3'd0, 3'd0, 3'd0, 4'd0, 13'h0123, 1'b1);
    wait_status();
    chk("mr2_nwr", wa.size(), 1);
    if (wa.size() > 0) begin chk("mr2_addr", wa[0], 0); chk("mr2_word", wd[0], 16'h6123); end
    chk("mr2_done", a_done, 1); chk("mr2_cnt", a_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
